// File: rtl/seg_dync_scan.sv
// Six-digit multiplexed seven-segment scanner.
//
// Each digit owns a slot of SCAN_TIME clocks. The first BLANK_TIME clocks
// of every slot keep all digits dark so the previous digit's segment
// pattern cannot ghost onto the next one. The value shown comes from a
// shadow copy of num taken once per frame, just as the scan wraps from
// digit 5 back to digit 0, so one frame never mixes two values.
//
// Output timing: sel, seg and frame are registered. What they show in a
// given cycle was computed from cnt/idx/shadow (and the live blank_lz /
// dp_mask inputs) during the previous cycle.
//
// Segment encoding is active-low: seg[7] = dp, seg[6:0] = g..a.
module seg_dync_scan #(
    parameter logic [23:0] SCAN_TIME  = 24'd50_000,
    parameter logic [23:0] BLANK_TIME = 24'd500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] num,
    input  logic        blank_lz,
    input  logic [5:0]  dp_mask,
    output logic [5:0]  sel,
    output logic [7:0]  seg,
    output logic        frame
);

    // ------------------------------------------------------------------
    // Scan position and shadow value
    // ------------------------------------------------------------------
    logic [23:0] cnt;
    logic [2:0]  idx;
    logic [23:0] shadow;

    logic        slot_end;
    logic        frame_end;

    assign slot_end  = (cnt == SCAN_TIME - 24'd1);
    assign frame_end = slot_end && (idx == 3'd5);

    // Advance within the slot; on the last clock move to the next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 24'd0;
            idx <= 3'd0;
        end else if (slot_end) begin
            cnt <= 24'd0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 24'd1;
        end
    end

    // Snapshot num as the scan returns to digit 0; flag it for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= 24'd0;
            frame  <= 1'b0;
        end else begin
            frame <= frame_end;
            if (frame_end) begin
                shadow <= num;
            end
        end
    end

    // ------------------------------------------------------------------
    // Glyph table: nibble -> active-low g..a pattern (hex glyphs for A-F)
    // ------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Per-digit selection from the shadow
    // ------------------------------------------------------------------
    logic [3:0] digit_nib;
    logic       digit_dp;
    logic       digit_upper_zero;  // this nibble and every nibble above it are zero

    // Pick the current digit's nibble, its dp bit, and whether it is a leading zero.
    always_comb begin
        digit_nib        = 4'h0;
        digit_dp         = 1'b0;
        digit_upper_zero = 1'b0;
        case (idx)
            3'd0: begin
                digit_nib        = shadow[3:0];
                digit_dp         = dp_mask[0];
                // Digit 0 is never a leading zero so "0" still shows.
                digit_upper_zero = 1'b0;
            end
            3'd1: begin
                digit_nib        = shadow[7:4];
                digit_dp         = dp_mask[1];
                digit_upper_zero = (shadow[23:4] == 20'd0);
            end
            3'd2: begin
                digit_nib        = shadow[11:8];
                digit_dp         = dp_mask[2];
                digit_upper_zero = (shadow[23:8] == 16'd0);
            end
            3'd3: begin
                digit_nib        = shadow[15:12];
                digit_dp         = dp_mask[3];
                digit_upper_zero = (shadow[23:12] == 12'd0);
            end
            3'd4: begin
                digit_nib        = shadow[19:16];
                digit_dp         = dp_mask[4];
                digit_upper_zero = (shadow[23:16] == 8'd0);
            end
            3'd5: begin
                digit_nib        = shadow[23:20];
                digit_dp         = dp_mask[5];
                digit_upper_zero = (shadow[23:20] == 4'd0);
            end
            default: begin
                digit_nib        = 4'h0;
                digit_dp         = 1'b0;
                digit_upper_zero = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next output values
    // ------------------------------------------------------------------
    logic       blank_phase;
    logic       lz_blank;
    logic [5:0] sel_next;
    logic [7:0] seg_next;

    // Blank phase darkens everything; the on phase enables one digit.
    always_comb begin
        blank_phase = (cnt < BLANK_TIME);
        lz_blank    = blank_lz && digit_upper_zero;
        sel_next    = 6'h3F;
        seg_next    = 8'hFF;
        if (!blank_phase) begin
            sel_next = ~(6'd1 << idx);
            // The decimal point stays independent of leading-zero blanking.
            seg_next = {~digit_dp, lz_blank ? 7'h7F : glyph(digit_nib)};
        end
    end

    // Register the pin drivers so no input reaches sel/seg combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 6'h3F;
            seg <= 8'hFF;
        end else begin
            sel <= sel_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_dync_scan.sv
// Bench for seg_dync_scan with a short scan (8 clocks per slot, 2 blank).
// The reference model works from the absolute number of clock edges since
// reset release: slot position, digit and frame boundaries fall out of
// plain division, and the displayed value comes from a glyph table.
module tb_seg_dync_scan;

    localparam int S = 8;
    localparam int B = 2;
    localparam int FRAME = 6 * S;

    logic        clk;
    logic        rst_n;
    logic [23:0] num;
    logic        blank_lz;
    logic [5:0]  dp_mask;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        frame;

    seg_dync_scan #(
        .SCAN_TIME (24'(S)),
        .BLANK_TIME(24'(B))
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .num     (num),
        .blank_lz(blank_lz),
        .dp_mask (dp_mask),
        .sel     (sel),
        .seg     (seg),
        .frame   (frame)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;
    logic [14:0] exp_q[$];        // {frame, sel, seg}
    int          edges;           // rising edges since reset release
    logic [23:0] model_shadow;    // value the display is showing this frame
    logic [6:0]  glyph_tab [16];

    initial begin
        glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    // Expected pins after edge e, given the scan state reached after e-1 edges.
    function automatic logic [14:0] model_out(input int e, input logic [23:0] sh,
                                              input logic blz, input logic [5:0] dp);
        int c, d;
        logic [5:0] s;
        logic [7:0] g;
        logic       f;
        c = (e - 1) % S;
        d = ((e - 1) / S) % 6;
        f = (e % FRAME) == 0;
        s = 6'h3F;
        g = 8'hFF;
        if (c >= B) begin
            s = 6'h3F ^ 6'(1 << d);
            g[7] = ~dp[d];
            if (blz && d != 0 && (sh >> (4 * d)) == 24'd0)
                g[6:0] = 7'h7F;
            else
                g[6:0] = glyph_tab[(sh >> (4 * d)) & 24'hF];
        end
        return {f, s, g};
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // One clock: predict at the rising edge, compare at the falling edge.
    task automatic step();
        logic [14:0] e;
        @(posedge clk);
        edges++;
        exp_q.push_back(model_out(edges, model_shadow, blank_lz, dp_mask));
        if (edges % FRAME == 0) model_shadow = num;
        @(negedge clk);
        e = exp_q.pop_front();
        check("frame", 32'(frame), 32'(e[14]));
        check("sel",   32'(sel),   32'(e[13:8]));
        check("seg",   32'(seg),   32'(e[7:0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_sel",   32'(sel),   32'h3F);
        check("rst_seg",   32'(seg),   32'hFF);
        check("rst_frame", 32'(frame), 32'h0);
        @(negedge clk);
        check("rst_hold_sel", 32'(sel), 32'h3F);
        rst_n = 1'b1;
        edges = 0;
        model_shadow = 24'd0;
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        num      = 24'h000000;
        blank_lz = 1'b1;
        dp_mask  = 6'h00;
        edges    = 0;
        model_shadow = 24'd0;

        do_reset();
        // First frame shows "0"; full frame plus wrap into the next.
        run(FRAME + 12);

        // Mid-frame update must not appear until the next capture.
        num = 24'h123456;
        run(2 * FRAME);

        // Leading zeros with an embedded zero, then suppression off.
        num = 24'h000907;
        run(FRAME + 20);
        blank_lz = 1'b0;
        run(FRAME);

        // Decimal point on a leading-zero-blanked digit.
        blank_lz = 1'b1;
        num      = 24'h000000;
        dp_mask  = 6'b000100;
        run(2 * FRAME);

        // Hex glyphs.
        dp_mask = 6'h00;
        num     = 24'hABCDEF;
        run(2 * FRAME);

        // Random traffic: live controls change often, num now and then.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) dp_mask  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0: num = 24'($urandom_range(0, 16'hFFFF));
                    1: num = 24'($urandom_range(0, 255)) << (4 * $urandom_range(0, 4));
                    default: num = 24'($urandom);
                endcase
            end
            step();
        end

        // Async reset in the middle of digit 3's slot (cnt = 5).
        num = 24'h987654;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((edges % S) == 5 && ((edges / S) % 6) == 3) break;
            step();
        end
        check("reached_cnt5_digit3", 32'((edges % S) == 5 && ((edges / S) % 6) == 3), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_sel",   32'(sel),   32'h3F);
        check("async_seg",   32'(seg),   32'hFF);
        check("async_frame", 32'(frame), 32'h0);
        @(negedge clk);
        check("async_hold_seg", 32'(seg), 32'hFF);
        rst_n = 1'b1;
        edges = 0;
        model_shadow = 24'd0;
        exp_q.delete();
        // Restart at digit 0 showing shadow 0, then pick up 987654.
        run(2 * FRAME + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
